// File: rtl/rs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rs_pkg
//  Description : GF(2^M) constant-arithmetic helpers and default parameters
//                for the Reed-Solomon syndrome front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package rs_pkg;

   localparam int         C_DEF_M         = 8;
   localparam int         C_DEF_N         = 255;
   localparam int         C_DEF_K         = 239;
   localparam logic [8:0] C_DEF_PRIM_POLY = 9'h11D;
   localparam int         C_DEF_FCR       = 0;
   localparam int         C_NSYN          = C_DEF_N - C_DEF_K;
   localparam int         C_IDX_W         = (C_NSYN > 1) ? $clog2(C_NSYN) : 1;
   localparam int         C_GF_MAX_W      = 16;

   typedef logic [C_GF_MAX_W-1:0] gf_elem_t;
   typedef logic [C_GF_MAX_W:0]   gf_poly_t;

   function automatic gf_elem_t gf_mul_alpha(input gf_elem_t a, input int m, input gf_poly_t poly);
      gf_poly_t r;
      gf_elem_t mask;
      r    = {a, 1'b0};
      mask = (gf_elem_t'(1) << m) - gf_elem_t'(1);
      if (r[m]) r = r ^ poly;
      return gf_elem_t'(r) & mask;
   endfunction

   // With c constant this collapses to a fixed XOR network.
   function automatic gf_elem_t gf_mul_const(input gf_elem_t a, input gf_elem_t c,
                                             input int m, input gf_poly_t poly);
      gf_elem_t acc;
      gf_elem_t p;
      acc = '0;
      p   = a;
      for (int b = 0; b < C_GF_MAX_W; b++) begin
         if ((b < m) && c[b]) acc = acc ^ p;
         p = gf_mul_alpha(p, m, poly);
      end
      return acc;
   endfunction

   function automatic gf_elem_t gf_alpha_pow(input int e, input int m, input gf_poly_t poly);
      gf_elem_t r;
      int       order;
      int       n;
      r     = gf_elem_t'(1);
      order = (1 << m) - 1;
      n     = ((e % order) + order) % order;
      for (int k = 0; k < n; k++) r = gf_mul_alpha(r, m, poly);
      return r;
   endfunction

endpackage : rs_pkg
`default_nettype wire

// File: rtl/rs_syn_cell.sv
`default_nettype none
// ============================================================================
//  Module      : rs_syn_cell
//  Description : One syndrome accumulator: Horner step by constant root
//                alpha^ROOT_EXP, loading the raw symbol on frame start.
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_syn_cell
   import rs_pkg::*;
#(
   parameter int         M         = C_DEF_M,
   parameter logic [M:0] PRIM_POLY = (M+1)'(C_DEF_PRIM_POLY),
   parameter int         ROOT_EXP  = C_DEF_FCR
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         load,
   input  logic [M-1:0] din,
   output logic [M-1:0] syn_next
);

   localparam gf_poly_t C_POLY = gf_poly_t'(PRIM_POLY);
   localparam gf_elem_t C_ROOT = gf_alpha_pow(ROOT_EXP, M, C_POLY);

   logic [M-1:0] r_syn;
   logic [M-1:0] w_scaled;

   assign w_scaled = M'(gf_mul_const(gf_elem_t'(r_syn), C_ROOT, M, C_POLY));
   assign syn_next = load ? din : (w_scaled ^ din);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_syn <= '0;
      end else if (en) begin
         r_syn <= syn_next;
      end
   end

endmodule : rs_syn_cell
`default_nettype wire

// File: rtl/rs_syndrome_unit.sv
`default_nettype none
// ============================================================================
//  Module      : rs_syndrome_unit
//  Description : Parametrised RS syndrome calculator with shadow bank and
//                ready/valid serial syndrome output. RS_SYN_ZERO_FLAG_EN adds
//                the syn_zero all-syndromes-zero flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_syndrome_unit
   import rs_pkg::*;
#(
   parameter int         M         = C_DEF_M,
   parameter int         N         = C_DEF_N,
   parameter int         K         = C_DEF_K,
   parameter int         T         = (N - K) / 2,
   parameter logic [M:0] PRIM_POLY = (M+1)'(C_DEF_PRIM_POLY),
   parameter int         FCR       = C_DEF_FCR,
   localparam int        NSYN      = 2 * T,
   localparam int        IDX_W     = (NSYN > 1) ? $clog2(NSYN) : 1
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             sync,
   input  logic             data_valid,
   input  logic [M-1:0]     data_in,
   input  logic             syn_ready,
   output logic             syn_valid,
   output logic [M-1:0]     syn_data,
   output logic [IDX_W-1:0] syn_idx,
   output logic             syn_last,
   output logic             frame_err,
   output logic             overflow,
   output logic             busy
`ifdef RS_SYN_ZERO_FLAG_EN
   ,
   output logic             syn_zero
`endif
);

   localparam int CNT_W = $clog2(N + 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_frame_err;
   logic             r_overflow;
   logic             r_syn_valid;
   logic [IDX_W-1:0] r_idx;
   logic [M-1:0]     r_bank [NSYN];
   logic [M-1:0]     w_syn_next [NSYN];

   logic w_load;
   logic w_take;
   logic w_last_sym;
   logic w_accept;
   logic w_drain_end;
   logic w_bank_free;
   logic w_bank_load;

   // A sync=0 symbol always (re)starts a frame; otherwise only mid-frame symbols count.
   assign w_load      = ~sync;
   assign w_take      = data_valid & (w_load | (r_cnt != '0));
   assign w_last_sym  = data_valid & sync & (r_cnt == CNT_W'(N - 1));
   assign w_accept    = r_syn_valid & syn_ready;
   assign w_drain_end = w_accept & (r_idx == IDX_W'(NSYN - 1));
   assign w_bank_free = ~r_syn_valid | w_drain_end;
   assign w_bank_load = w_last_sym & w_bank_free;

   generate
      for (genvar i = 0; i < NSYN; i++) begin : g_cell
         rs_syn_cell #(
            .M         (M),
            .PRIM_POLY (PRIM_POLY),
            .ROOT_EXP  (FCR + i)
         ) u_cell (
            .clk      (clk_in),
            .rst_n    (rst_n),
            .en       (w_take),
            .load     (w_load),
            .din      (data_in),
            .syn_next (w_syn_next[i])
         );
      end
   endgenerate

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= data_valid & w_load & (r_cnt != '0);
         if (w_take) begin
            if (w_load)                          r_cnt <= CNT_W'(1);
            else if (r_cnt == CNT_W'(N - 1))     r_cnt <= '0;
            else                                 r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // Shadow bank drains as a shift register; zeros fill in behind so syn_data idles at 0.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_syn_valid <= 1'b0;
         r_idx       <= '0;
         r_overflow  <= 1'b0;
         for (int i = 0; i < NSYN; i++) r_bank[i] <= '0;
      end else begin
         r_overflow <= w_last_sym & ~w_bank_free;
         if (w_bank_load) begin
            r_syn_valid <= 1'b1;
            r_idx       <= '0;
            for (int i = 0; i < NSYN; i++) r_bank[i] <= w_syn_next[i];
         end else if (w_accept) begin
            if (w_drain_end) begin
               r_syn_valid <= 1'b0;
               r_idx       <= '0;
            end else begin
               r_idx <= r_idx + 1'b1;
            end
            for (int i = 0; i < NSYN - 1; i++) r_bank[i] <= r_bank[i+1];
            r_bank[NSYN-1] <= '0;
         end
      end
   end

`ifdef RS_SYN_ZERO_FLAG_EN
   logic r_syn_zero;
   logic w_any_nz;

   always_comb begin
      w_any_nz = 1'b0;
      for (int i = 0; i < NSYN; i++) w_any_nz = w_any_nz | (|w_syn_next[i]);
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_syn_zero <= 1'b0;
      end else if (w_bank_load) begin
         r_syn_zero <= ~w_any_nz;
      end
   end

   assign syn_zero = r_syn_zero;
`endif

   assign syn_valid = r_syn_valid;
   assign syn_data  = r_bank[0];
   assign syn_idx   = r_idx;
   assign syn_last  = r_syn_valid & (r_idx == IDX_W'(NSYN - 1));
   assign frame_err = r_frame_err;
   assign overflow  = r_overflow;
   assign busy      = (r_cnt != '0);

endmodule : rs_syndrome_unit
`default_nettype wire

// File: tb/tb_rs_syndrome_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs_syndrome_unit
//  Description : Directed, table-driven bench for rs_syndrome_unit (N=255,
//                K=239, 0x11D, FCR=0) with independent GF syndrome model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_syndrome_unit;

   localparam int NS = 255;
   localparam int NQ = 16;

   logic       clk_in = 1'b0;
   logic       rst_n;
   logic       sync;
   logic       data_valid;
   logic [7:0] data_in;
   logic       syn_ready;
   logic       syn_valid;
   logic [7:0] syn_data;
   logic [3:0] syn_idx;
   logic       syn_last;
   logic       frame_err;
   logic       overflow;
   logic       busy;
`ifdef RS_SYN_ZERO_FLAG_EN
   logic       syn_zero;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] frame   [NS];
   logic [7:0] exp_syn [NQ];
   logic [7:0] got_syn [NQ];

   typedef struct {
      int         pos;
      logic [7:0] val;
      logic [7:0] e0;
      logic [7:0] e1;
      logic [7:0] e15;
   } vec_t;

   vec_t vecs [5];

   rs_syndrome_unit dut (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .sync       (sync),
      .data_valid (data_valid),
      .data_in    (data_in),
      .syn_ready  (syn_ready),
      .syn_valid  (syn_valid),
      .syn_data   (syn_data),
      .syn_idx    (syn_idx),
      .syn_last   (syn_last),
      .frame_err  (frame_err),
      .overflow   (overflow),
      .busy       (busy)
`ifdef RS_SYN_ZERO_FLAG_EN
      ,
      .syn_zero   (syn_zero)
`endif
   );

   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Bit-serial GF(256) multiply, reduction by 0x11D.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] p;
      logic [7:0] r;
      r = 8'h00;
      p = {1'b0, a};
      for (int k = 0; k < 8; k++) begin
         if (b[k]) r = r ^ p[7:0];
         p = p << 1;
         if (p[8]) p = p ^ 9'h11D;
      end
      return r;
   endfunction

   task automatic model();
      logic [7:0] root;
      logic [7:0] s;
      root = 8'h01;
      for (int i = 0; i < NQ; i++) begin
         s = 8'h00;
         for (int j = 0; j < NS; j++) s = gmul(s, root) ^ frame[j];
         exp_syn[i] = s;
         root = gmul(root, 8'h02);
      end
   endtask

   task automatic set_single(input int pos, input logic [7:0] val);
      for (int j = 0; j < NS; j++) frame[j] = 8'h00;
      frame[pos] = val;
      model();
   endtask

   // ready_from >= 0 drives syn_ready high from that symbol onward.
   task automatic send_frame(input int ready_from, input int gap_pct);
      for (int j = 0; j < NS; j++) begin
         while ($urandom_range(99) < gap_pct) begin
            data_valid = 1'b0;
            sync       = 1'($urandom_range(1));
            data_in    = 8'($urandom_range(255));
            if (ready_from >= 0) syn_ready = (j >= ready_from);
            tick();
         end
         if (ready_from >= 0) syn_ready = (j >= ready_from);
         data_valid = 1'b1;
         sync       = (j != 0);
         data_in    = frame[j];
         tick();
      end
      data_valid = 1'b0;
      sync       = 1'b1;
      data_in    = 8'h00;
   endtask

   task automatic drain(input int start);
      int  w;
      logic all_zero;
      w = 0;
      while (!syn_valid && w < 400) begin
         tick();
         w++;
      end
      if (!syn_valid) begin
         check("drain_timeout", 32'(syn_valid), 32'd1);
         return;
      end
      all_zero = 1'b1;
      for (int i = 0; i < NQ; i++) all_zero = all_zero & (exp_syn[i] == 8'h00);
      syn_ready = 1'b1;
      for (int k = start; k < NQ; k++) begin
         check("drain_valid", 32'(syn_valid), 32'd1);
         check("drain_idx",   32'(syn_idx),   32'(k));
         check("drain_data",  32'(syn_data),  32'(exp_syn[k]));
         check("drain_last",  32'(syn_last),  32'(k == NQ - 1));
`ifdef RS_SYN_ZERO_FLAG_EN
         check("drain_zero",  32'(syn_zero),  32'(all_zero));
`endif
         got_syn[k] = syn_data;
         tick();
      end
      check("drain_end_valid", 32'(syn_valid), 32'd0);
   endtask

   task automatic check_idle(input string name);
      check({name, "_valid"}, 32'(syn_valid), 32'd0);
      check({name, "_data"},  32'(syn_data),  32'd0);
      check({name, "_idx"},   32'(syn_idx),   32'd0);
      check({name, "_last"},  32'(syn_last),  32'd0);
      check({name, "_ferr"},  32'(frame_err), 32'd0);
      check({name, "_ovf"},   32'(overflow),  32'd0);
      check({name, "_busy"},  32'(busy),      32'd0);
`ifdef RS_SYN_ZERO_FLAG_EN
      check({name, "_zero"},  32'(syn_zero),  32'd0);
`endif
   endtask

   initial begin
      int pulses;

      vecs[0] = '{pos: 0,   val: 8'h00, e0: 8'h00, e1: 8'h00, e15: 8'h00};
      vecs[1] = '{pos: 0,   val: 8'h01, e0: 8'h01, e1: 8'h8E, e15: 8'h2C};
      vecs[2] = '{pos: 254, val: 8'h05, e0: 8'h05, e1: 8'h05, e15: 8'h05};
      vecs[3] = '{pos: 253, val: 8'h01, e0: 8'h01, e1: 8'h02, e15: 8'h26};
      vecs[4] = '{pos: 254, val: 8'hFF, e0: 8'hFF, e1: 8'hFF, e15: 8'hFF};

      rst_n      = 1'b0;
      sync       = 1'b1;
      data_valid = 1'b0;
      data_in    = 8'h00;
      syn_ready  = 1'b1;
      tick();
      tick();
      check_idle("reset");
      rst_n = 1'b1;
      tick();

      // Single-symbol frames against hand values and the model.
      for (int v = 0; v < 5; v++) begin
         set_single(vecs[v].pos, vecs[v].val);
         send_frame(-1, 0);
         check("vec_valid_c1", 32'(syn_valid), 32'd1);
         drain(0);
         check("vec_s0",  32'(got_syn[0]),  32'(vecs[v].e0));
         check("vec_s1",  32'(got_syn[1]),  32'(vecs[v].e1));
         check("vec_s15", 32'(got_syn[15]), 32'(vecs[v].e15));
      end

      // Backpressure stall at idx 3, then overflow from a second frame.
      syn_ready = 1'b0;
      set_single(253, 8'h01);
      send_frame(-1, 0);
      syn_ready = 1'b1;
      for (int k = 0; k < 3; k++) tick();
      syn_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check("stall_idx",  32'(syn_idx),  32'd3);
         check("stall_data", 32'(syn_data), 32'h08);
         tick();
      end
      set_single(254, 8'h05);
      send_frame(-1, 0);
      check("ovf_pulse", 32'(overflow), 32'd1);
      check("ovf_idx",   32'(syn_idx),  32'd3);
      check("ovf_data",  32'(syn_data), 32'h08);
      tick();
      check("ovf_clear", 32'(overflow), 32'd0);
      set_single(253, 8'h01);
      drain(3);

      // Drain end coinciding with the next bank load: no bubble.
      syn_ready = 1'b0;
      set_single(253, 8'h01);
      send_frame(-1, 0);
      set_single(254, 8'h05);
      send_frame(NS - NQ, 0);
      check("b2b_valid", 32'(syn_valid), 32'd1);
      check("b2b_idx",   32'(syn_idx),   32'd0);
      check("b2b_data",  32'(syn_data),  32'h05);
      check("b2b_ovf",   32'(overflow),  32'd0);
      drain(0);

      // Mid-frame sync restarts the frame.
      for (int j = 0; j < 100; j++) begin
         data_valid = 1'b1;
         sync       = (j != 0);
         data_in    = 8'($urandom_range(1, 255));
         tick();
      end
      data_valid = 1'b1;
      sync       = 1'b0;
      data_in    = 8'h00;
      tick();
      check("ferr_pulse", 32'(frame_err), 32'd1);
      check("ferr_busy",  32'(busy),      32'd1);
      pulses = 0;
      for (int j = 1; j < NS; j++) begin
         sync    = 1'b1;
         data_in = 8'h00;
         tick();
         if (frame_err) pulses++;
      end
      data_valid = 1'b0;
      check("ferr_once", 32'(pulses), 32'd0);
      check("ferr_valid", 32'(syn_valid), 32'd1);
      set_single(0, 8'h00);
      drain(0);

      // Random data with 50% valid gaps.
      for (int j = 0; j < NS; j++) frame[j] = 8'($urandom_range(255));
      model();
      send_frame(-1, 50);
      drain(0);

      // Reset mid-drain, then reset mid-frame, then a clean frame.
      set_single(254, 8'h05);
      send_frame(-1, 0);
      tick();
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1 check_idle("rst_drain");
      tick();
      rst_n = 1'b1;
      tick();
      check_idle("post_rst");
      for (int j = 0; j < 50; j++) begin
         data_valid = 1'b1;
         sync       = (j != 0);
         data_in    = 8'($urandom_range(255));
         tick();
      end
      check("mid_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      data_valid = 1'b0;
      tick();
      check_idle("rst_frame");
      rst_n = 1'b1;
      tick();
      set_single(254, 8'h05);
      send_frame(-1, 0);
      drain(0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_rs_syndrome_unit
`default_nettype wire

// File: doc/rs_syndrome_unit.md
Name: rs_syndrome_unit

Overview:
- Parametrised syndrome calculator and front end of the Reed-Solomon decoder.
- Generalises the fixed t=8, m=8 syndrome stage: N, K, symbol width, field polynomial and first consecutive root are all parameters.
- Adds a per-symbol valid qualifier, a ready/valid syndrome output with a one-frame shadow bank, abort/overflow reporting, and asynchronous reset.
- Sits between the received symbol stream and the Berlekamp-Massey stage, which consumes the 2T syndromes serially.

Parameters:
- M, 8, symbol width in bits.
- N, 255, codeword length in symbols (N ≤ 2^M-1).
- K, 239, message length in symbols.
- T, (N-K)/2, correctable symbols; 2T syndromes produced.
- PRIM_POLY, 9'h11D, GF(2^M) primitive polynomial, M+1 bits.
- FCR, 0, first consecutive root exponent; S_i uses root alpha^(FCR+i).

Ports:
- clk_in  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sync  in  1  active-low frame start, qualified by data_valid; marks the first (highest-degree) symbol.
- data_valid  in  1  data_in holds a symbol this cycle.
- data_in  in  M  received symbol.
- syn_ready  in  1  downstream accepts a syndrome.
- syn_valid  out  1  syn_data/syn_idx valid.
- syn_data  out  M  syndrome S_idx.
- syn_idx  out  $clog2(2T)  syndrome index, 0..2T-1.
- syn_last  out  1  high with idx 2T-1.
- frame_err  out  1  one-cycle pulse: frame aborted by sync mid-frame.
- overflow  out  1  one-cycle pulse: completed frame dropped because the shadow bank was busy.
- busy  out  1  accumulating a frame (symbol count ≠ 0).

Behaviour:
- Reset: all accumulators, counters and shadow bank cleared. syn_valid, syn_last, frame_err, overflow, busy = 0; syn_data = 0; syn_idx = 0. Reset is honoured mid-frame and mid-drain; the partial frame is discarded and no pulses are emitted.
- Accumulate:
  - On each accepted symbol (data_valid=1): S_i ← S_i·alpha^(FCR+i) XOR data_in, for all i in parallel.
  - The first symbol of a frame (sync=0) loads S_i ← data_in, ignoring the old value.
  - data_valid=0 pauses the frame; no state changes.
- Symbol counter runs 0..N-1 and wraps to 0 after the Nth accepted symbol.
- Symbols with sync=1 while the counter is 0 are ignored (idle, no sync seen).
- sync=0 with counter ≠ 0:
  - frame_err pulses next cycle;
  - the current symbol restarts the frame as symbol 0 (counter → 1).
- Frame completion, Nth symbol accepted in cycle c:
  - If the shadow bank is empty, the final S_i copy to the shadow bank in cycle c (the copy includes symbol N's contribution). syn_valid rises at c+1 with idx 0.
  - If the shadow bank is not empty, overflow pulses at c+1, the new syndromes are discarded, and the draining frame is unaffected.
- A sync-marked first symbol of the next frame in cycle c+1 is legal; back-to-back frames have no gap.
- Drain:
  - One syndrome per cycle when syn_valid & syn_ready; idx increments.
  - syn_data, syn_idx and syn_last are held stable while syn_valid=1 & syn_ready=0.
  - After idx 2T-1 is accepted, syn_valid drops the next cycle unless another bank load occurs that same cycle, in which case idx 0 of the new frame is presented with no bubble.
- Arithmetic: GF(2^M) multiply by constants only, reducing by PRIM_POLY; constants alpha^(FCR+i) are computed at elaboration. No general multipliers.
- Full throughput: 1 symbol per clock sustained, provided the drain (2T cycles) finishes within N symbol times.

Optional Feature:
- Macro: RS_SYN_ZERO_FLAG_EN.
- Defined: adds output syn_zero (1 bit), registered at bank load. It is high when all 2T syndromes of the loaded frame are zero, is valid while syn_valid=1, and resets to 0. Downstream uses it to bypass BM/Chien/Forney.
- Undefined: port and OR-reduction logic are absent; behaviour is otherwise identical.

Decomposition:
- Package rs_pkg:
  - gf_mul_const function (M, PRIM_POLY);
  - gf_alpha_pow function computing alpha^e at elaboration;
  - default PRIM_POLY/FCR constants;
  - localparam for syndrome count 2T and index width.
- One natural sub-module: rs_syn_cell, a single syndrome accumulator (Horner step with constant root, load-on-first), generated 2T times.

Test Plan:
- All-zero frame, N=255, T=8: 16 syndromes, all 0x00, idx 0..15, syn_last on idx 15; syn_zero=1 when enabled.
- Zero codeword except first symbol = 0x01 (FCR=0, 0x11D): S_0=0x01, S_1=0x8E (alpha^254); S_i=alpha^(255-i) generally.
- Zero codeword except last symbol = 0x05: all 16 syndromes = 0x05; syn_valid one cycle after the last symbol.
- Backpressure: syn_ready low for 5 cycles at idx 3 → syn_data and idx held stable; a second frame completing before the drain finishes → overflow pulse, and the first frame's syndromes are intact.
- sync=0 at symbol 100, then 255 symbols of a valid codeword → frame_err pulse once, then all-zero syndromes for the restarted frame.
- data_valid toggled 50% randomly, and rst_n asserted mid-drain → correct syndromes with gaps; after reset all outputs are 0 and the next frame decodes cleanly.
